// File: rtl/scroll_field_pkg.sv
// Shared types and constants for the scroll_field playfield block.
package scroll_field_pkg;

  // Width of the collision query box dimensions (q_w / q_h)
  localparam int QDIM_W = 4;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} q_state_t;

  typedef enum logic [1:0] {BOTTOM, TOP, MID, BOTH} pat_t;

endpackage

// File: rtl/scroll_field_if.sv
// Column feed, pixel read port and collision query port of scroll_field.
// master = the client (screen updater / physics / column source), slave = scroll_field.
interface scroll_field_if #(
  parameter int ROWS = 100,
  parameter int XW   = 8,
  parameter int YW   = 7
);
  import scroll_field_pkg::*;

  logic                shift_req;
  logic [ROWS-1:0]     col_in;
  logic                col_valid;
  logic                col_ready;
  logic                rd_en;
  logic [XW-1:0]       rd_x;
  logic [YW-1:0]       rd_y;
  logic                rd_data;
  logic                rd_valid;
  logic                q_start;
  logic [XW-1:0]       q_x;
  logic [YW-1:0]       q_y;
  logic [QDIM_W-1:0]   q_w;
  logic [QDIM_W-1:0]   q_h;
  logic                q_busy;
  logic                q_done;
  logic                q_hit;
  logic [15:0]         scroll_count;

  modport master (
    output shift_req, col_in, col_valid, rd_en, rd_x, rd_y, q_start, q_x, q_y, q_w, q_h,
    input  col_ready, rd_data, rd_valid, q_busy, q_done, q_hit, scroll_count
  );

  modport slave (
    input  shift_req, col_in, col_valid, rd_en, rd_x, rd_y, q_start, q_x, q_y, q_w, q_h,
    output col_ready, rd_data, rd_valid, q_busy, q_done, q_hit, scroll_count
  );

endinterface

// File: rtl/scroll_field_pattern_gen.sv
// Built-in column source: cycles BOTTOM -> TOP -> MID -> BOTH, one step per accepted shift.
// Only instantiated when SCROLL_FIELD_PATTERN_EN is defined.
module scroll_pattern_gen
  import scroll_field_pkg::*;
#(
  parameter int ROWS = 100,
  parameter int BAND = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_advance,
  output logic [ROWS-1:0] o_col
);

  pat_t r_pat;

  // Pattern index; 2-bit increment wraps BOTH back to BOTTOM
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_pat <= BOTTOM;
    else if (i_advance) r_pat <= pat_t'(r_pat + 2'd1);
  end

  // Column image for the current pattern
  always_comb begin
    o_col = '0;
    for (int y = 0; y < ROWS; y++) begin
      case (r_pat)
        BOTTOM:  o_col[y] = (y >= ROWS - BAND);
        TOP:     o_col[y] = (y < BAND);
        MID:     o_col[y] = (y >= BAND + 10) && (y <= ROWS - BAND - 11);
        default: o_col[y] = (y < BAND) || (y >= ROWS - BAND);
      endcase
    end
  end

endmodule

// File: rtl/scroll_field.sv
// Scrolling COLS x ROWS playfield stored as a ring buffer of columns, with a
// 1-cycle pixel read port and a one-cell-per-cycle rectangle collision query.
// Optional macro SCROLL_FIELD_PATTERN_EN replaces col_in/col_valid with the
// internal pattern generator.
//
// state | meaning
// IDLE  | accepting shifts and new queries
// SCAN  | testing one query cell per cycle; shifts blocked
// DONE  | one-cycle q_done pulse, then back to IDLE
module scroll_field
  import scroll_field_pkg::*;
#(
  parameter int COLS      = 120,
  parameter int ROWS      = 100,
  parameter int XW        = 8,
  parameter int YW        = 7,
  parameter bit OOB_SOLID = 1'b1,
  parameter int BAND      = 20
) (
  input  logic          clk,
  input  logic          reset,
  scroll_field_if.slave bus
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [XW:0]   C_COLS = (XW+1)'(COLS);
  localparam logic [YW:0]   C_ROWS = (YW+1)'(ROWS);
  localparam logic [XW-1:0] C_LAST = XW'(COLS - 1);

  logic [ROWS-1:0]   r_field [COLS];
  logic [XW-1:0]     r_head;
  logic [15:0]       r_count;
  q_state_t          r_state, w_state_nxt;
  logic [XW-1:0]     r_qx;
  logic [YW-1:0]     r_qy;
  logic [QDIM_W-1:0] r_qw, r_qh, r_cx, r_cy;
  logic              r_hit;
  logic              r_rd_data, r_rd_valid;

  logic [ROWS-1:0]   w_col;
  logic              w_col_valid;
  logic              w_accept;
  logic [XW:0]       w_sx;
  logic [YW:0]       w_sy;
  logic              w_cell;
  logic              w_last;

  // Logical (x, y) -> stored bit; coordinates outside the field give oob
  function automatic logic cell_at(input logic [XW:0] x, input logic [YW:0] y, input logic oob);
    logic [XW:0]     phys;
    logic [ROWS-1:0] col;
    logic            res;
    if (x >= C_COLS || y >= C_ROWS) begin
      res = oob;
    end else begin
      phys = {1'b0, r_head} + x;
      if (phys >= C_COLS) phys = phys - C_COLS;
      col = r_field[phys[CW-1:0]];
      res = col[y[RW-1:0]];
    end
    return res;
  endfunction

`ifdef SCROLL_FIELD_PATTERN_EN
  scroll_pattern_gen #(.ROWS(ROWS), .BAND(BAND)) u_pattern_gen (
    .clk       (clk),
    .reset     (reset),
    .i_advance (w_accept),
    .o_col     (w_col)
  );
  assign w_col_valid = 1'b1;
`else
  assign w_col       = bus.col_in;
  assign w_col_valid = bus.col_valid;
`endif

  assign bus.col_ready    = (r_state == IDLE);
  assign w_accept         = bus.shift_req & w_col_valid & bus.col_ready;
  assign w_sx             = {1'b0, r_qx} + (XW+1)'(r_cx);
  assign w_sy             = {1'b0, r_qy} + (YW+1)'(r_cy);
  assign w_cell           = cell_at(w_sx, w_sy, OOB_SOLID);
  assign w_last           = (r_cx == r_qw - 1'b1) && (r_cy == r_qh - 1'b1);
  assign bus.q_busy       = (r_state == SCAN);
  assign bus.q_done       = (r_state == DONE);
  assign bus.q_hit        = r_hit;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.scroll_count = r_count;

  // Column store, head pointer and scroll counter; new column overwrites the old logical x = 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) r_field[i] <= '0;
      r_head  <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_field[r_head[CW-1:0]] <= w_col;
      r_head  <= (r_head == C_LAST) ? '0 : r_head + 1'b1;
      r_count <= r_count + 16'd1;
    end
  end

  // Pixel read; sees the pre-shift field when a shift lands in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      r_rd_data  <= bus.rd_en & cell_at({1'b0, bus.rd_x}, {1'b0, bus.rd_y}, 1'b0);
    end
  end

  // Query state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Query next-state: empty boxes skip SCAN, first hit exits early
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.q_start) w_state_nxt = (bus.q_w == '0 || bus.q_h == '0) ? DONE : SCAN;
      SCAN: if (w_cell || w_last) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Query box latch, column-major scan counters and hit flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_qx  <= '0;
      r_qy  <= '0;
      r_qw  <= '0;
      r_qh  <= '0;
      r_cx  <= '0;
      r_cy  <= '0;
      r_hit <= 1'b0;
    end else if (r_state == IDLE && bus.q_start) begin
      r_qx  <= bus.q_x;
      r_qy  <= bus.q_y;
      r_qw  <= bus.q_w;
      r_qh  <= bus.q_h;
      r_cx  <= '0;
      r_cy  <= '0;
      r_hit <= 1'b0;
    end else if (r_state == SCAN) begin
      if (w_cell) begin
        r_hit <= 1'b1;
      end else if (r_cy == r_qh - 1'b1) begin
        r_cy <= '0;
        r_cx <= r_cx + 1'b1;
      end else begin
        r_cy <= r_cy + 1'b1;
      end
    end
  end

endmodule
